// File: rtl/mod_updown_counter.sv
// mod_updown_counter: bounded up/down counter over 0..limit with wrap or
// saturate boundary behaviour, synchronous load and registered event pulses.
// Optional feature macro: UDC_PRESCALE_EN builds a prescaler that gates
// steps to one per (psc_div + 1) enabled cycles; when it is undefined,
// psc_div is ignored and every enabled, non-load cycle is a step.
module mod_updown_counter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir_sel,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    input  logic [PSC_W-1:0] psc_div,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat_hit
);

    logic             step_c;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

`ifdef UDC_PRESCALE_EN
    logic [PSC_W-1:0] psc_cnt;
    logic [PSC_W-1:0] psc_nxt;

    // Prescaler: count enabled cycles, fire a step when the count reaches psc_div.
    always_comb begin
        psc_nxt = psc_cnt;
        step_c  = 1'b0;
        if (load) begin
            psc_nxt = '0;
        end else if (en) begin
            if (psc_cnt == psc_div) begin
                psc_nxt = '0;
                step_c  = 1'b1;
            end else begin
                psc_nxt = psc_cnt + PSC_W'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_nxt;
        end
    end
`else
    logic unused_psc_div;
    assign unused_psc_div = ^psc_div;

    // Without a prescaler every enabled cycle that is not a load is a step.
    always_comb begin
        step_c = en & ~load;
    end
`endif

    // Next count and event pulses: load beats step, step beats hold.
    always_comb begin
        q_nxt    = q;
        tc_nxt   = 1'b0;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (load) begin
            q_nxt = (load_val > limit) ? limit : load_val;
        end else if (step_c) begin
            if (dir_sel) begin
                if (q < limit) begin
                    q_nxt  = q + WIDTH'(1);
                    tc_nxt = ((q + WIDTH'(1)) == limit);
                end else if (sat_mode) begin
                    q_nxt   = limit;
                    tc_nxt  = 1'b1;
                    sat_nxt = 1'b1;
                end else begin
                    q_nxt    = '0;
                    tc_nxt   = 1'b1;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (q != '0) begin
                    q_nxt  = q - WIDTH'(1);
                    tc_nxt = (q == WIDTH'(1));
                end else if (sat_mode) begin
                    q_nxt   = '0;
                    tc_nxt  = 1'b1;
                    sat_nxt = 1'b1;
                end else begin
                    q_nxt    = limit;
                    tc_nxt   = 1'b1;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    // Output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            tc      <= 1'b0;
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end else begin
            q       <= q_nxt;
            tc      <= tc_nxt;
            wrap    <= wrap_nxt;
            sat_hit <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed scenarios plus randomized traffic checked
// against a behavioural model of the counter rules.
module tb_mod_updown_counter;

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          dir_sel = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [W-1:0]  limit = '0;
    logic          sat_mode = 1'b0;
    logic [PW-1:0] psc_div = '0;
    logic [W-1:0]  q;
    logic          tc;
    logic          wrap;
    logic          sat_hit;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint m_q = 0;
    bit     m_tc = 0;
    bit     m_wrap = 0;
    bit     m_sat = 0;
    int     m_psc = 0;

    mod_updown_counter #(.WIDTH(W), .PSC_W(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .dir_sel(dir_sel), .load(load),
        .load_val(load_val), .limit(limit), .sat_mode(sat_mode),
        .psc_div(psc_div), .q(q), .tc(tc), .wrap(wrap), .sat_hit(sat_hit)
    );

    always #5 clk = ~clk;

    // Behavioural rules applied at a rising edge, using the inputs seen there.
    task automatic model_edge();
        longint lim;
        bit     step;
        lim = longint'(limit);
        if (rst) begin
            m_q = 0; m_tc = 0; m_wrap = 0; m_sat = 0; m_psc = 0;
            return;
        end
        m_tc = 0; m_wrap = 0; m_sat = 0;
        if (load) begin
            m_q   = (longint'(load_val) < lim) ? longint'(load_val) : lim;
            m_psc = 0;
            return;
        end
        step = en;
`ifdef UDC_PRESCALE_EN
        if (en) begin
            if (m_psc == int'(psc_div)) m_psc = 0;
            else begin m_psc = m_psc + 1; step = 0; end
        end
`endif
        if (!step) return;
        if (dir_sel) begin
            if (m_q < lim) m_q = m_q + 1;
            else if (sat_mode) begin m_q = lim; m_sat = 1; end
            else begin m_q = 0; m_wrap = 1; end
            m_tc = (m_q == lim) || m_wrap;
        end else begin
            if (m_q > 0) m_q = m_q - 1;
            else if (sat_mode) begin m_q = 0; m_sat = 1; end
            else begin m_q = lim; m_wrap = 1; end
            m_tc = (m_q == 0) || m_wrap;
        end
    endtask

    // Advance one clock, update the model, settle to sampling point.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic [W-1:0] lim);
        load = 1'b1; load_val = v; limit = lim;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({q, tc, wrap, sat_hit} !== {W'(0), 3'b000}) begin
            errors++;
            $display("FAIL reset_async: got q=%0h tc=%b wrap=%b sat=%b, want all 0", q, tc, wrap, sat_hit);
        end
        en = 1'b1;
        tick();
        tick();
        checks++;
        if ({q, tc, wrap, sat_hit} !== {W'(0), 3'b000}) begin
            errors++;
            $display("FAIL reset_hold: got q=%0h tc=%b wrap=%b sat=%b, want all 0", q, tc, wrap, sat_hit);
        end
        en = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wrap_up();
        logic [W-1:0] exp_q [6] = '{1, 2, 3, 4, 5, 0};
        bit exp_tc [6] = '{0, 0, 0, 0, 1, 1};
        bit exp_wr [6] = '{0, 0, 0, 0, 0, 1};
        psc_div = '0; sat_mode = 1'b0; dir_sel = 1'b1; en = 1'b0;
        do_load(W'(0), W'(5));
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({q, tc, wrap, sat_hit} !== {exp_q[i], exp_tc[i], exp_wr[i], 1'b0}) begin
                errors++;
                $display("FAIL wrap_up[%0d]: got q=%0d tc=%b wrap=%b sat=%b, want q=%0d tc=%b wrap=%b sat=0",
                         i, q, tc, wrap, sat_hit, exp_q[i], exp_tc[i], exp_wr[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_sat_down();
        psc_div = '0; sat_mode = 1'b1; dir_sel = 1'b0; en = 1'b0;
        do_load(W'(1), W'(5));
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({q, tc, wrap, sat_hit} !== {W'(0), 1'b1, 1'b0, (i != 0)}) begin
                errors++;
                $display("FAIL sat_down[%0d]: got q=%0d tc=%b wrap=%b sat=%b, want q=0 tc=1 wrap=0 sat=%b",
                         i, q, tc, wrap, sat_hit, (i != 0));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_clamp();
        psc_div = '0; sat_mode = 1'b0; dir_sel = 1'b1;
        en = 1'b1;
        do_load(W'(9), W'(5));
        checks++;
        if ({q, tc, wrap, sat_hit} !== {W'(5), 3'b000}) begin
            errors++;
            $display("FAIL load_clamp: got q=%0d tc=%b wrap=%b sat=%b, want q=5 no pulses", q, tc, wrap, sat_hit);
        end
        tick();
        checks++;
        if ({q, tc, wrap, sat_hit} !== {W'(0), 3'b110}) begin
            errors++;
            $display("FAIL load_then_wrap: got q=%0d tc=%b wrap=%b sat=%b, want q=0 tc=1 wrap=1 sat=0", q, tc, wrap, sat_hit);
        end
        en = 1'b0;
    endtask

    task automatic test_limit_change();
        psc_div = '0; sat_mode = 1'b1; dir_sel = 1'b1; en = 1'b0;
        do_load(W'(8), W'(10));
        limit = W'(4);
        tick();
        checks++;
        if ({q, tc, wrap, sat_hit} !== {W'(8), 3'b000}) begin
            errors++;
            $display("FAIL limit_hold: got q=%0d tc=%b wrap=%b sat=%b, want q=8 no pulses", q, tc, wrap, sat_hit);
        end
        en = 1'b1;
        tick();
        checks++;
        if ({q, tc, wrap, sat_hit} !== {W'(4), 3'b101}) begin
            errors++;
            $display("FAIL limit_lowered: got q=%0d tc=%b wrap=%b sat=%b, want q=4 tc=1 wrap=0 sat=1", q, tc, wrap, sat_hit);
        end
        en = 1'b0;
    endtask

    task automatic test_limit_zero();
        psc_div = '0; en = 1'b0;
        do_load(W'(7), W'(0));
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dir_sel  = i[0];
            sat_mode = i[1];
            tick();
            checks++;
            if ({q, tc, wrap, sat_hit} !== {W'(0), 1'b1, ~sat_mode, sat_mode}) begin
                errors++;
                $display("FAIL limit_zero[%0d]: got q=%0d tc=%b wrap=%b sat=%b, want q=0 tc=1 wrap=%b sat=%b",
                         i, q, tc, wrap, sat_hit, ~sat_mode, sat_mode);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        psc_div = '0; sat_mode = 1'b0; dir_sel = 1'b1; en = 1'b0;
        do_load(W'('h1230), W'('hFFFF));
        en = 1'b1;
        repeat (4) tick();
        checks++;
        if (q !== W'('h1234)) begin
            errors++;
            $display("FAIL pre_reset_count: got q=%0h, want 1234", q);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({q, tc, wrap, sat_hit} !== {W'(0), 3'b000}) begin
            errors++;
            $display("FAIL mid_reset: got q=%0h tc=%b wrap=%b sat=%b, want all 0", q, tc, wrap, sat_hit);
        end
        m_q = 0; m_tc = 0; m_wrap = 0; m_sat = 0; m_psc = 0;
        rst = 1'b0;
        tick();
        checks++;
        if ({q, tc, wrap, sat_hit} !== {W'(1), 3'b000}) begin
            errors++;
            $display("FAIL resume_after_reset: got q=%0h tc=%b wrap=%b sat=%b, want q=1 no pulses", q, tc, wrap, sat_hit);
        end
        en = 1'b0;
    endtask

`ifdef UDC_PRESCALE_EN
    task automatic test_prescale();
        bit           en_pat [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
        logic [W-1:0] exp_q  [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2};
        sat_mode = 1'b0; dir_sel = 1'b1; en = 1'b0; psc_div = PW'(3);
        do_load(W'(0), W'(100));
        for (int i = 0; i < 10; i++) begin
            en = en_pat[i];
            tick();
            checks++;
            if (q !== exp_q[i]) begin
                errors++;
                $display("FAIL prescale[%0d]: got q=%0d, want %0d", i, q, exp_q[i]);
            end
        end
        en = 1'b0; psc_div = '0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) < 8);
            load     = ($urandom_range(0, 19) == 0);
            dir_sel  = $urandom_range(0, 1) == 1;
            sat_mode = $urandom_range(0, 1) == 1;
            load_val = W'($urandom_range(0, 20));
            if ($urandom_range(0, 15) == 0) limit = W'($urandom_range(0, 12));
            psc_div  = PW'($urandom_range(0, 2));
            tick();
            checks++;
            if ({q, tc, wrap, sat_hit} !== {W'(m_q), m_tc, m_wrap, m_sat}) begin
                errors++;
                $display("FAIL random[%0d]: got q=%0d tc=%b wrap=%b sat=%b, want q=%0d tc=%b wrap=%b sat=%b",
                         i, q, tc, wrap, sat_hit, m_q, m_tc, m_wrap, m_sat);
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_limit_change();
        test_limit_zero();
        test_async_reset();
`ifdef UDC_PRESCALE_EN
        test_prescale();
`endif
        limit = W'(6);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
